mmio_io_ctrl: RTL and testbench
===============================

Name: mmio_io_ctrl

Overview:
- Memory-mapped I/O controller that produces io_dout for the load-data selector; responds when addr[31:28] == 4'b1000.
- Holds the UART transmit holding register, an RX FIFO in front of the UART receiver, a cycle counter and a retired-instruction counter.
- Read data is registered (1-cycle latency) so it arrives in the same cycle as data from the synchronous dmem/BIOS memories.

Parameters:
- RX_DEPTH, 8, RX FIFO entries; power of two, at least 2.
- CLK_CNT_W, 32, width of both counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  32  byte address from execute stage
- wdata  in  32  store data
- we  in  1  store strobe, qualified by addr[31:28]==4'b1000
- re  in  1  load strobe, qualified by addr[31:28]==4'b1000
- inst_retire  in  1  one instruction retired this cycle
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  FIFO can accept a byte
- io_dout  out  32  registered read data

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. Assertion clears all state immediately: io_dout=0, tx_valid=0, tx_data=0, FIFO empty, both counters 0, rx_ready=1 after release.
- Register map (addr[7:0], word aligned, addr[1:0] ignored):
  - 0x00 status, read-only: {30'b0, rx_nonempty, tx_free}. tx_free = ~tx_valid.
  - 0x04 rx data, read-only: {24'b0, FIFO head}. A read pops the FIFO if it is non-empty. A read of an empty FIFO returns 0 and pops nothing.
  - 0x08 tx data, write-only: a write while tx_free loads wdata[7:0] and sets tx_valid. A write while tx_valid=1 is dropped; tx_data is unchanged.
  - 0x10 cycle counter, read-only: increments every cycle.
  - 0x14 instruction counter, read-only: increments when inst_retire=1.
  - 0x18 counter reset, write-only: any write clears both counters.
  - Unmapped reads return 0; unmapped writes are ignored. Writes to read-only addresses are ignored.
- Read latency: io_dout updates on the clock edge after re and holds its value until the next qualified re. The value returned is the pre-pop FIFO head and the pre-edge counter value.
- TX handshake: tx_valid and tx_data stay stable until a cycle with tx_valid && tx_ready. tx_valid then clears on that edge. A write in that same handshake cycle is still dropped, because tx_free is evaluated before the edge.
- RX FIFO:
  - Push when rx_valid && rx_ready.
  - rx_ready = ~full. This is combinational from registered pointers, not from rx_valid.
  - Pointers carry an extra wrap bit so full and empty can be distinguished.
  - Push and pop in the same cycle on a non-empty, non-full FIFO keep the count unchanged and ordering intact.
  - Push and pop on an empty FIFO: the pop is a no-op and the push succeeds.
  - On a full FIFO, a pop frees a slot but rx_ready stays low that cycle. No overwrite ever occurs.
- Counters: CLK_CNT_W-bit, wrap from all-ones to 0 with no flag. If a clear and an increment happen in the same cycle, the clear wins and the counter is 0 after the edge.
- Simultaneous we and re in one cycle: both take effect independently.

Test Plan:
- Reset: assert rst_n=0 mid-transfer with tx_valid=1 and FIFO holding 3 bytes -> immediately tx_valid=0, io_dout=0. After release, read 0x00 returns 0x1 and read 0x04 returns 0.
- TX: write 0x41 to 0x08 with tx_ready=0 for 5 cycles -> tx_valid=1 and tx_data=0x41 stable. Write 0x42 during that window -> dropped. Raise tx_ready for 1 cycle -> tx_valid=0, then status reads 0x1.
- RX fill: push 8 bytes 0x10..0x17 -> rx_ready=0 after the 8th; a 9th rx_valid is not accepted. Eight reads of 0x04 return 0x10..0x17 in order; a 9th read returns 0.
- RX concurrent: with 4 bytes queued, push one byte and read 0x04 in the same cycle -> occupancy stays 4 and the read returns the oldest byte.
- Counters: after 100 cycles with retire on alternate cycles, read 0x10 -> 100 and 0x14 -> 50 (±1 for read timing, checked exactly by bench model). Write 0x18 in a cycle with inst_retire=1 -> both read 0 plus the elapsed cycles afterwards.
- Wrap: force the cycle counter to 0xFFFFFFFF -> the next cycle reads 0x00000000.

Source files
------------

// File: rtl/mmio_io_ctrl.sv
// MMIO block at 0x8xxx_xxxx: UART TX holding register, RX FIFO, cycle and
// retired-instruction counters. Reads are registered to line up with the synchronous memories.
module mmio_io_ctrl #(
    parameter int RX_DEPTH  = 8,
    parameter int CLK_CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        inst_retire,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] io_dout
);

    localparam int AW = $clog2(RX_DEPTH);

    localparam logic [5:0] OFF_STATUS = 6'h00;
    localparam logic [5:0] OFF_RX     = 6'h01;
    localparam logic [5:0] OFF_TX     = 6'h02;
    localparam logic [5:0] OFF_CYC    = 6'h04;
    localparam logic [5:0] OFF_INST   = 6'h05;
    localparam logic [5:0] OFF_CLR    = 6'h06;

    logic                 sel;
    logic                 wr;
    logic                 rd;
    logic [5:0]           off;
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [7:0]           mem [RX_DEPTH];
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 cnt_clr;
    logic [CLK_CNT_W-1:0] cyc_cnt;
    logic [CLK_CNT_W-1:0] inst_cnt;
    logic [31:0]          rdata;
    logic                 unused_bits;

    assign sel = (addr[31:28] == 4'b1000);
    assign wr  = we & sel;
    assign rd  = re & sel;
    assign off = addr[7:2];

    assign unused_bits = ^{addr[27:8], addr[1:0], wdata[31:8]};

    // Extra wrap bit on each pointer separates full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_ready = ~full;
    assign push     = rx_valid & ~full;
    assign pop      = rd && (off == OFF_RX) && !empty;
    assign cnt_clr  = wr && (off == OFF_CLR);

    always_comb begin
        rdata = '0;
        case (off)
            OFF_STATUS: rdata = {30'b0, ~empty, ~tx_valid};
            OFF_RX:     rdata = empty ? 32'h0 : {24'b0, mem[rd_ptr[AW-1:0]]};
            OFF_CYC:    rdata = 32'(cyc_cnt);
            OFF_INST:   rdata = 32'(inst_cnt);
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_dout  <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else begin
            if (rd) begin
                io_dout <= rdata;
            end
            // tx_free is sampled before the edge, so a write during the handshake is dropped.
            if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end else if (wr && (off == OFF_TX) && !tx_valid) begin
                tx_valid <= 1'b1;
                tx_data  <= wdata[7:0];
            end
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (cnt_clr) begin
                cyc_cnt  <= '0;
                inst_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + CLK_CNT_W'(1);
                if (inst_retire) begin
                    inst_cnt <= inst_cnt + CLK_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl: register-map vector table plus hand sequences
// for RX FIFO, reset, counters and counter wrap (on a narrow-counter instance).
module tb_mmio_io_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        inst_retire;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] io_dout;

    logic [7:0]  unused_s_tx_data;
    logic        unused_s_tx_valid;
    logic        unused_s_rx_ready;
    logic [31:0] s_dout;

    int tests;
    int fails;

    mmio_io_ctrl #(.RX_DEPTH(8), .CLK_CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .inst_retire(inst_retire), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .io_dout(io_dout)
    );

    // Narrow counters so wrap-around is reachable in a few cycles.
    mmio_io_ctrl #(.RX_DEPTH(2), .CLK_CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .inst_retire(inst_retire), .tx_data(unused_s_tx_data),
        .tx_valid(unused_s_tx_valid), .tx_ready(1'b0), .rx_data(8'h00),
        .rx_valid(1'b0), .rx_ready(unused_s_rx_ready), .io_dout(s_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        tx_ready;
        logic [31:0] exp_dout;
        logic        exp_txv;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] got);
        addr = a;
        re   = 1'b1;
        tick();
        re   = 1'b0;
        got  = io_dout;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        tests = 0;
        fails = 0;
        rst_n = 1'b0; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
        inst_retire = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

        //                we    re    addr          wdata         txr   dout   txv   txd
        vt[0]  = '{1'b0, 1'b1, 32'h8000_0000, 32'h0,        1'b0, 32'h1, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 1'b0, 32'h8000_0008, 32'h41,       1'b0, 32'h1, 1'b1, 8'h41};
        vt[2]  = '{1'b0, 1'b1, 32'h8000_0000, 32'h0,        1'b0, 32'h0, 1'b1, 8'h41};
        vt[3]  = '{1'b1, 1'b0, 32'h8000_0008, 32'h42,       1'b0, 32'h0, 1'b1, 8'h41};
        vt[4]  = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,        1'b0, 32'h0, 1'b1, 8'h41};
        vt[5]  = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,1'b0, 32'h0, 1'b1, 8'h41};
        vt[6]  = '{1'b1, 1'b0, 32'h8000_0008, 32'h43,       1'b1, 32'h0, 1'b0, 8'h41};
        vt[7]  = '{1'b0, 1'b1, 32'h8000_0000, 32'h0,        1'b0, 32'h1, 1'b0, 8'h41};
        vt[8]  = '{1'b0, 1'b1, 32'h8000_000C, 32'h0,        1'b0, 32'h0, 1'b0, 8'h41};
        vt[9]  = '{1'b0, 1'b1, 32'h8000_0003, 32'h0,        1'b0, 32'h1, 1'b0, 8'h41};
        vt[10] = '{1'b0, 1'b1, 32'h0000_000C, 32'h0,        1'b0, 32'h1, 1'b0, 8'h41};
        vt[11] = '{1'b1, 1'b0, 32'h0000_0008, 32'h55,       1'b0, 32'h1, 1'b0, 8'h41};
        vt[12] = '{1'b1, 1'b0, 32'h8000_0008, 32'h5A,       1'b0, 32'h1, 1'b1, 8'h5A};
        vt[13] = '{1'b0, 1'b1, 32'h8000_0000, 32'h0,        1'b1, 32'h0, 1'b0, 8'h5A};

        tick();
        tick();
        check("reset_dout", io_dout, 32'h0);
        check("reset_txv", {31'b0, tx_valid}, 32'h0);
        check("reset_txd", {24'b0, tx_data}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("reset_rx_ready", {31'b0, rx_ready}, 32'h1);

        for (int i = 0; i < 14; i++) begin
            we = vt[i].we; re = vt[i].re; addr = vt[i].addr;
            wdata = vt[i].wdata; tx_ready = vt[i].tx_ready;
            tick();
            we = 1'b0; re = 1'b0; tx_ready = 1'b0;
            check($sformatf("vec%0d_dout", i), io_dout, vt[i].exp_dout);
            check($sformatf("vec%0d_txv", i), {31'b0, tx_valid}, {31'b0, vt[i].exp_txv});
            check($sformatf("vec%0d_txd", i), {24'b0, tx_data}, {24'b0, vt[i].exp_txd});
        end

        // RX fill to full, rejected pushes, drain in order.
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h10 + 8'(i);
            tick();
        end
        rx_valid = 1'b0;
        check("fill_rx_ready", {31'b0, rx_ready}, 32'h0);
        rx_valid = 1'b1; rx_data = 8'h98;
        tick();
        rx_valid = 1'b0;
        rd(32'h8000_0000, got);
        check("fill_status", got, 32'h3);
        addr = 32'h8000_0004; re = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
        #1;
        check("full_pop_rx_ready", {31'b0, rx_ready}, 32'h0);
        tick();
        re = 1'b0; rx_valid = 1'b0;
        check("drain0", io_dout, 32'h10);
        for (int i = 1; i < 8; i++) begin
            rd(32'h8000_0004, got);
            check($sformatf("drain%0d", i), got, 32'h10 + 32'(i));
        end
        rd(32'h8000_0004, got);
        check("drain_empty", got, 32'h0);
        check("drain_rx_ready", {31'b0, rx_ready}, 32'h1);

        // Concurrent push and pop with 4 queued.
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h20 + 8'(i);
            tick();
        end
        addr = 32'h8000_0004; re = 1'b1; rx_valid = 1'b1; rx_data = 8'h24;
        tick();
        re = 1'b0; rx_valid = 1'b0;
        check("conc_pop", io_dout, 32'h20);
        for (int i = 1; i < 5; i++) begin
            rd(32'h8000_0004, got);
            check($sformatf("conc%0d", i), got, 32'h20 + 32'(i));
        end
        rd(32'h8000_0004, got);
        check("conc_empty", got, 32'h0);

        // Push and pop on an empty FIFO.
        addr = 32'h8000_0004; re = 1'b1; rx_valid = 1'b1; rx_data = 8'h30;
        tick();
        re = 1'b0; rx_valid = 1'b0;
        check("empty_pp_dout", io_dout, 32'h0);
        rd(32'h8000_0004, got);
        check("empty_pp_byte", got, 32'h30);

        // Asynchronous reset mid-transfer.
        wr(32'h8000_0008, 32'h77);
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h50 + 8'(i);
            tick();
        end
        rx_valid = 1'b0;
        rd(32'h8000_0000, got);
        check("pre_reset_status", got, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dout", io_dout, 32'h0);
        check("async_rst_txv", {31'b0, tx_valid}, 32'h0);
        check("async_rst_txd", {24'b0, tx_data}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        rd(32'h8000_0000, got);
        check("post_rst_status", got, 32'h1);
        rd(32'h8000_0004, got);
        check("post_rst_rx", got, 32'h0);

        // Counter clear wins over a same-cycle retire.
        inst_retire = 1'b1;
        wr(32'h8000_0018, 32'h0);
        inst_retire = 1'b0;
        rd(32'h8000_0010, got);
        check("clr_cyc", got, 32'h0);
        rd(32'h8000_0014, got);
        check("clr_inst", got, 32'h0);

        inst_retire = 1'b1;
        wr(32'h8000_0018, 32'h0);
        for (int i = 0; i < 100; i++) begin
            inst_retire = (i % 2 == 0);
            tick();
        end
        inst_retire = 1'b0;
        rd(32'h8000_0010, got);
        check("cyc_100", got, 32'd100);
        rd(32'h8000_0014, got);
        check("inst_50", got, 32'd50);

        // Wrap: the 4-bit instance reaches all-ones 15 cycles after a clear.
        wr(32'h8000_0018, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        rd(32'h8000_0010, got);
        check("wrap_max", s_dout, 32'hF);
        rd(32'h8000_0010, got);
        check("wrap_zero", s_dout, 32'h0);
        check("wrap_wide", got, 32'd16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
